wb_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave arbiter for the pipelined Wishbone B4 bus (stall/ack/err) used across the softcore fabric. It lets the CPU fetch port, data port and DMA/loader masters share one slave bus. Arbitration is round-robin with a registered grant held for a whole `cyc` burst. The block also bounds outstanding transactions and recovers from non-responding slaves with a timeout error.

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_rr_picker.sv | 32 +++
 rtl/wb_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone arbitration blocks.
// No logic: arbiter state encoding and the grant-index width helper.
// Backpressure: n/a.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

    // Width of a master index; a single master still needs one bit.
    function automatic int idxw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: first requester searching upward from last+1 with wrap.
// Latency: combinational.
// Backpressure: none; vld low when no request is present.
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int NM = 2,
    localparam int IDXW = idxw(NM)
) (
    input  logic [NM-1:0]   req,
    input  logic [IDXW-1:0] last,
    output logic            vld,
    output logic [IDXW-1:0] idx
);

    int best_d;

    // Rotational distance from last+1; the nearest requester wins.
    always_comb begin
        vld    = 1'b0;
        idx    = '0;
        best_d = NM;
        for (int i = 0; i < NM; i++) begin
            if (req[i] && (((i + 2 * NM - int'(last) - 1) % NM) < best_d)) begin
                vld    = 1'b1;
                idx    = IDXW'(i);
                best_d = (i + 2 * NM - int'(last) - 1) % NM;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter, round-robin, grant held per cyc.
// Latency: grant 1 cycle after cyc in idle; request and response paths combinational.
// Backpressure: granted master stalls on slave stall or MAX_OUT outstanding; others always stall.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int SELW    = 4,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NM-1:0]      i_m_cyc,
    input  logic [NM-1:0]      i_m_stb,
    input  logic [NM-1:0]      i_m_we,
    input  logic [NM*SELW-1:0] i_m_sel,
    input  logic [NM*AW-1:0]   i_m_addr,
    input  logic [NM*DW-1:0]   i_m_data,
    output logic [NM-1:0]      o_m_stall,
    output logic [NM-1:0]      o_m_ack,
    output logic [NM-1:0]      o_m_err,
    output logic [DW-1:0]      o_m_data,
    output logic               o_s_cyc,
    output logic               o_s_stb,
    output logic               o_s_we,
    output logic [SELW-1:0]    o_s_sel,
    output logic [AW-1:0]      o_s_addr,
    output logic [DW-1:0]      o_s_data,
    input  logic               i_s_stall,
    input  logic               i_s_ack,
    input  logic               i_s_err,
    input  logic [DW-1:0]      i_s_data
);

    localparam int IDXW = idxw(NM);
    localparam int CW   = $clog2(MAX_OUT + 1);
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t      state, state_nxt;
    logic [IDXW-1:0] gnt, gnt_nxt;
    logic [IDXW-1:0] last, last_nxt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;
    logic [CW-1:0]   outstanding, out_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_nxt;
    logic            g_cyc, g_stb, full, busy, s_resp, accept, tmo_fire;

    wb_rr_picker #(.NM(NM)) u_picker (
        .req  (i_m_cyc),
        .last (last),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    assign g_cyc    = i_m_cyc[gnt];
    assign g_stb    = i_m_stb[gnt];
    assign full     = (outstanding == CW'(MAX_OUT));
    assign busy     = (outstanding != '0);
    // Responses with nothing outstanding are strays and never reach a master.
    assign s_resp   = (i_s_ack | i_s_err) & busy;
    assign accept   = o_s_stb & ~i_s_stall;
    assign tmo_fire = (TIMEOUT != 0) && (state == GRANT) && g_cyc && busy
                      && !(i_s_ack | i_s_err) && (tmo_cnt == TW'(TIMEOUT - 1));

    assign o_s_we   = i_m_we[gnt];
    assign o_s_sel  = i_m_sel[gnt * SELW +: SELW];
    assign o_s_addr = i_m_addr[gnt * AW +: AW];
    assign o_s_data = i_m_data[gnt * DW +: DW];
    assign o_m_data = i_s_data;

    // The timeout cycle also blocks new strobes so no accept is lost in the abort.
    always_comb begin
        o_s_cyc   = 1'b0;
        o_s_stb   = 1'b0;
        o_m_stall = '1;
        o_m_ack   = '0;
        o_m_err   = '0;
        if (state == GRANT) begin
            o_s_cyc        = g_cyc;
            o_s_stb        = g_cyc & g_stb & ~full & ~tmo_fire;
            o_m_stall[gnt] = i_s_stall | full | tmo_fire;
            o_m_ack[gnt]   = i_s_ack & busy;
            o_m_err[gnt]   = (i_s_err & busy) | tmo_fire;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        out_nxt   = outstanding;
        tmo_nxt   = tmo_cnt;
        case (state)
            IDLE: begin
                out_nxt = '0;
                tmo_nxt = '0;
                if (pick_vld) begin
                    gnt_nxt   = pick_idx;
                    last_nxt  = pick_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!g_cyc) begin
                    state_nxt = IDLE;
                    out_nxt   = '0;
                    tmo_nxt   = '0;
                end else if (tmo_fire) begin
                    state_nxt = RECOVER;
                    out_nxt   = '0;
                    tmo_nxt   = '0;
                end else begin
                    if (accept && !s_resp) begin
                        out_nxt = outstanding + 1'b1;
                    end else if (!accept && s_resp) begin
                        out_nxt = outstanding - 1'b1;
                    end
                    if ((TIMEOUT != 0) && busy && !(i_s_ack | i_s_err)) begin
                        tmo_nxt = tmo_cnt + 1'b1;
                    end else begin
                        tmo_nxt = '0;
                    end
                end
            end
            RECOVER: begin
                out_nxt = '0;
                tmo_nxt = '0;
                if (!g_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            gnt         <= '0;
            last        <= IDXW'(NM - 1);
            outstanding <= '0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            last        <= last_nxt;
            outstanding <= out_nxt;
            tmo_cnt     <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed plus randomized bench for wb_rr_arbiter with an integer-level reference model.
module tb_wb_rr_arbiter;

    localparam int NM      = 3;
    localparam int AW      = 30;
    localparam int DW      = 32;
    localparam int SELW    = 4;
    localparam int MAX_OUT = 3;
    localparam int TIMEOUT = 8;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic [NM-1:0]      i_m_cyc, i_m_stb, i_m_we;
    logic [NM*SELW-1:0] i_m_sel;
    logic [NM*AW-1:0]   i_m_addr;
    logic [NM*DW-1:0]   i_m_data;
    logic [NM-1:0]      o_m_stall, o_m_ack, o_m_err;
    logic [DW-1:0]      o_m_data;
    logic               o_s_cyc, o_s_stb, o_s_we;
    logic [SELW-1:0]    o_s_sel;
    logic [AW-1:0]      o_s_addr;
    logic [DW-1:0]      o_s_data;
    logic               i_s_stall, i_s_ack, i_s_err;
    logic [DW-1:0]      i_s_data;

    int total = 0;
    int bad   = 0;
    int g, last_m, mask_i, acc, out_m, quiet;
    bit found;
    logic [NM-1:0] e_m;
    logic          e_b;

    always #5 i_clk = ~i_clk;

    wb_rr_arbiter #(
        .NM(NM), .AW(AW), .DW(DW), .SELW(SELW), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we), .i_m_sel(i_m_sel),
        .i_m_addr(i_m_addr), .i_m_data(i_m_data),
        .o_m_stall(o_m_stall), .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_data(o_m_data),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
        .o_s_addr(o_s_addr), .o_s_data(o_s_data),
        .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_err(i_s_err), .i_s_data(i_s_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    function automatic logic [NM-1:0] oh(input int i);
        return NM'(1) << i;
    endfunction

    function automatic logic [AW-1:0] base_addr(input int i);
        return AW'(32'h100 + i);
    endfunction

    initial begin
        i_reset = 1'b1; i_m_cyc = '0; i_m_stb = '0; i_m_we = '0; i_m_sel = '0;
        i_s_stall = 1'b0; i_s_ack = 1'b1; i_s_err = 1'b0; i_s_data = '0;
        for (int i = 0; i < NM; i++) begin
            i_m_addr[i*AW +: AW] = base_addr(i);
            i_m_data[i*DW +: DW] = DW'(32'hD000_0000 + i);
        end
        step(); step(); look();
        chk("rst_cyc", o_s_cyc, 0);
        chk("rst_stb", o_s_stb, 0);
        e_m = '1; chk("rst_stall", o_m_stall, e_m);
        chk("rst_ack", o_m_ack, 0);
        chk("rst_err", o_m_err, 0);
        i_reset = 1'b0; i_s_ack = 1'b0;
        step();

        // Every master requests: 2-cycle bursts, grants rotate 0,1,2,0.
        i_m_cyc = '1; look(); chk("rr_idle", o_s_cyc, 0); step();
        for (int b = 0; b < 4; b++) begin
            g = b % NM;
            for (int k = 0; k < 2; k++) begin
                look();
                chk("rr_cyc", o_s_cyc, 1);
                chk("rr_addr", o_s_addr, base_addr(g));
                e_m = ~oh(g); chk("rr_stall", o_m_stall, e_m);
                step();
            end
            i_m_cyc[g] = 1'b0; look(); chk("rr_release", o_s_cyc, 0); step();
            i_m_cyc[g] = 1'b1; look(); chk("rr_dead", o_s_cyc, 0); step();
        end
        i_m_cyc = '0; step(); step();
        last_m = 1;

        // Random request masks against a rotating-search model.
        for (int n = 0; n < 24; n++) begin
            mask_i = int'($urandom_range(0, (1 << NM) - 1));
            i_m_cyc = NM'(mask_i);
            look(); chk("rrr_idle", o_s_cyc, 0); step();
            found = 1'b0;
            for (int k = 1; k <= NM; k++) begin
                if (!found && (((mask_i >> ((last_m + k) % NM)) & 1) != 0)) begin
                    found = 1'b1;
                    g = (last_m + k) % NM;
                end
            end
            look();
            if (found) begin
                chk("rrr_cyc", o_s_cyc, 1);
                chk("rrr_addr", o_s_addr, base_addr(g));
                last_m = g;
            end else begin
                chk("rrr_none", o_s_cyc, 0);
            end
            step();
            i_m_cyc = '0; step();
        end

        // MAX_OUT limit: five back-to-back strobes, slave never acks.
        i_m_cyc = 3'b001; step();
        i_m_stb[0] = 1'b1; acc = 0;
        for (int k = 0; k < 5; k++) begin
            look();
            e_b = (k >= MAX_OUT); chk("lim_stall", o_m_stall[0], e_b);
            if (o_s_stb && !i_s_stall) acc++;
            step();
        end
        chk("lim_accepts", acc, MAX_OUT);
        i_s_ack = 1'b1; look();
        e_m = oh(0); chk("lim_ack", o_m_ack, e_m);
        chk("lim_full_stb", o_s_stb, 0);
        step();
        i_s_ack = 1'b0; acc = 0;
        for (int k = 0; k < 3; k++) begin
            look();
            if (o_s_stb && !i_s_stall) acc++;
            step();
        end
        chk("lim_one_more", acc, 1);
        i_m_stb = '0; i_s_ack = 1'b1;
        for (int k = 0; k < MAX_OUT; k++) begin
            look(); e_m = oh(0); chk("drain_ack", o_m_ack, e_m); step();
        end
        look(); chk("drain_stray", o_m_ack, 0); step();

        // Accept and ack in the same cycle keep the count at one.
        i_s_ack = 1'b0; i_m_stb[0] = 1'b1; look(); chk("sim_stb0", o_s_stb, 1); step();
        i_s_ack = 1'b1; look(); chk("sim_stb1", o_s_stb, 1);
        e_m = oh(0); chk("sim_ack", o_m_ack, e_m); step();
        i_m_stb = '0; look(); e_m = oh(0); chk("sim_left_one", o_m_ack, e_m); step();
        look(); chk("sim_empty", o_m_ack, 0); step();
        i_s_ack = 1'b0;

        // Randomized pipelined traffic on master 0 against an outstanding-count model.
        out_m = 0; quiet = 0;
        for (int n = 0; n < 300; n++) begin
            i_m_stb[0] = 1'($urandom_range(0, 1));
            i_m_we[0] = 1'($urandom_range(0, 1));
            i_m_sel[0 +: SELW] = SELW'($urandom);
            i_m_addr[0 +: AW] = AW'($urandom);
            i_m_data[0 +: DW] = DW'($urandom);
            i_s_stall = ($urandom_range(0, 3) == 0);
            i_s_ack = (quiet >= 4) || ($urandom_range(0, 1) == 1);
            i_s_data = DW'($urandom);
            look();
            e_b = i_m_stb[0] && (out_m < MAX_OUT); chk("rnd_stb", o_s_stb, e_b);
            e_m = '1; e_m[0] = i_s_stall || (out_m == MAX_OUT); chk("rnd_stall", o_m_stall, e_m);
            e_m = '0; e_m[0] = i_s_ack && (out_m != 0); chk("rnd_ack", o_m_ack, e_m);
            chk("rnd_addr", o_s_addr, i_m_addr[0 +: AW]);
            chk("rnd_wdata", o_s_data, i_m_data[0 +: DW]);
            chk("rnd_rdata", o_m_data, i_s_data);
            quiet = ((out_m != 0) && !i_s_ack) ? quiet + 1 : 0;
            out_m = out_m + ((e_b && !i_s_stall) ? 1 : 0) - ((i_s_ack && out_m != 0) ? 1 : 0);
            step();
        end
        i_m_stb = '0; i_s_stall = 1'b0; i_s_ack = 1'b1;
        repeat (MAX_OUT) step();
        i_s_ack = 1'b0; i_m_cyc = '0; i_m_addr[0 +: AW] = base_addr(0);
        step(); step();

        // Timeout: one accepted read on master 1, slave silent; master 2 waits.
        i_m_cyc = 3'b110; step();
        i_m_stb[1] = 1'b1; look();
        chk("tmo_addr", o_s_addr, base_addr(1));
        chk("tmo_accept", o_s_stb, 1);
        step();
        i_m_stb = '0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            look();
            e_m = (k == TIMEOUT) ? oh(1) : '0; chk("tmo_err", o_m_err, e_m);
            chk("tmo_cyc", o_s_cyc, 1);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            look();
            chk("rec_cyc", o_s_cyc, 0);
            chk("rec_err", o_m_err, 0);
            e_m = '1; chk("rec_stall", o_m_stall, e_m);
            step();
        end
        i_m_cyc[1] = 1'b0; look(); chk("rec_drop", o_s_cyc, 0); step();
        look(); chk("rec_idle", o_s_cyc, 0); step();
        look(); chk("rec_next_cyc", o_s_cyc, 1); chk("rec_next_addr", o_s_addr, base_addr(2));

        // Abort with two outstanding, then two stray acks.
        i_m_stb[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            look(); chk("abt_stb", o_s_stb, 1); step();
        end
        i_m_stb = '0; i_m_cyc[2] = 1'b0; look(); chk("abt_cyc", o_s_cyc, 0); step();
        i_s_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            look(); chk("abt_stray", o_m_ack, 0); step();
        end
        i_s_ack = 1'b0; i_m_cyc = 3'b100; step();
        i_s_ack = 1'b1; look();
        chk("abt_cleared", o_m_ack, 0);
        chk("abt_not_full", o_m_stall[2], 0);
        step();
        i_s_ack = 1'b0; i_m_cyc = '0; step(); step();

        // Reset with three outstanding on master 1.
        i_m_cyc = 3'b010; step();
        i_m_stb[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            look(); chk("rst_fill", o_s_stb, 1); step();
        end
        i_m_stb = '0; i_m_cyc = '1; i_reset = 1'b1; step();
        i_s_ack = 1'b1; look();
        chk("mid_rst_cyc", o_s_cyc, 0);
        e_m = '1; chk("mid_rst_stall", o_m_stall, e_m);
        chk("mid_rst_ack", o_m_ack, 0);
        i_reset = 1'b0; step();
        look();
        chk("post_rst_cyc", o_s_cyc, 1);
        chk("post_rst_prio", o_s_addr, base_addr(0));
        chk("post_rst_out", o_m_ack, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
